// File: rtl/wd_feeder_pkg.sv
// Shared types and defaults for the watchdog feeder.
// Holds the state encoding, the timing defaults and the jitter LFSR constants.
package wd_pkg;

  typedef enum logic [2:0] {
    DISABLED = 3'd0,
    LOW      = 3'd1,
    HIGH     = 3'd2,
    STARVE   = 3'd3,
    RECOVER  = 3'd4
  } wd_feeder_state_t;

  localparam int WD_FEED_HIGH  = 8;
  localparam int WD_FEED_LOW   = 8;
  localparam int WD_ALIVE_WIN  = 256;
  localparam int WD_MAX_BITES  = 3;

  localparam logic [7:0] WD_LFSR_SEED = 8'hA5;
  // Taps 8,6,5,4 expressed as a mask over bits [7:0].
  localparam logic [7:0] WD_LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] wd_lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & WD_LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/wd_feeder_alive_mon.sv
// Heartbeat window monitor: counts run cycles since the last alive pulse and
// flags the cycle on which the window would expire.
module wd_alive_mon
  import wd_pkg::*;
#(
  parameter int ALIVE_WIN = WD_ALIVE_WIN,
  parameter int CNT_W     = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic run_i,
  input  logic alive_i,
  output logic expired_o
);

  logic [CNT_W-1:0] win_q;
  logic [CNT_W-1:0] win_d;

  assign expired_o = run_i && !alive_i && (win_q == CNT_W'(ALIVE_WIN - 1));

  // Outside the run states the counter simply holds its value.
  always_comb begin
    win_d = win_q;
    if (clear_i || (run_i && alive_i)) begin
      win_d = '0;
    end else if (run_i && !expired_o) begin
      win_d = win_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q <= '0;
    end else begin
      win_q <= win_d;
    end
  end

endmodule

// File: rtl/wd_feeder.sv
// Watchdog feeder: bounded feed pulses, heartbeat-driven starvation, bite counting.
// Define WD_FEEDER_JITTER_EN to stretch each LOW phase by 0..3 cycles from an LFSR.
module wd_feeder
  import wd_pkg::*;
#(
  parameter int FEED_HIGH = WD_FEED_HIGH,
  parameter int FEED_LOW  = WD_FEED_LOW,
  parameter int ALIVE_WIN = WD_ALIVE_WIN,
  parameter int MAX_BITES = WD_MAX_BITES,
  parameter int CNT_W     = 16,
  parameter int BITE_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              alive,
  input  logic              wdog,
  output logic              feed,
  output logic              starving,
  output logic [BITE_W-1:0] bite_cnt,
  output logic              spurious_bite,
  output logic              rst_req
);

  wd_feeder_state_t  state_q, state_d;
  logic [CNT_W-1:0]  phase_q, phase_d;
  logic [BITE_W-1:0] bite_q, bite_d, bite_inc;
  logic              rst_req_q, rst_req_d;
  logic              spur_q, spur_d;
  logic              feed_q, feed_d;
  logic              starving_q, starving_d;
  logic              run, expired, win_clr;
  logic [CNT_W-1:0]  low_len;

  assign run = (state_q == LOW) || (state_q == HIGH);

  wd_alive_mon #(
    .ALIVE_WIN (ALIVE_WIN),
    .CNT_W     (CNT_W)
  ) u_alive_mon (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (win_clr),
    .run_i     (run),
    .alive_i   (alive),
    .expired_o (expired)
  );

`ifdef WD_FEEDER_JITTER_EN
  logic [7:0] lfsr_q;
  logic       low_entry;

  assign low_entry = (state_d == LOW) && (state_q != LOW);

  // The LFSR steps on LOW entry, so the whole LOW phase sees the fresh value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= WD_LFSR_SEED;
    end else if (low_entry) begin
      lfsr_q <= wd_lfsr_next(lfsr_q);
    end
  end

  assign low_len = CNT_W'(FEED_LOW) + CNT_W'(lfsr_q[1:0]);
`else
  assign low_len = CNT_W'(FEED_LOW);
`endif

  assign bite_inc = (&bite_q) ? bite_q : bite_q + BITE_W'(1);

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q + CNT_W'(1);
    bite_d    = bite_q;
    rst_req_d = rst_req_q;
    spur_d    = spur_q | (wdog && (state_q != STARVE));
    win_clr   = 1'b0;
    if (!en) begin
      state_d   = DISABLED;
      phase_d   = '0;
      bite_d    = '0;
      rst_req_d = 1'b0;
      win_clr   = 1'b1;
    end else begin
      // A heartbeat in a run state breaks the consecutive-bite streak.
      if (alive && run) begin
        bite_d = '0;
      end
      unique case (state_q)
        DISABLED: begin
          state_d = LOW;
          phase_d = '0;
          win_clr = 1'b1;
        end
        LOW: begin
          if (expired) begin
            state_d = STARVE;
            phase_d = '0;
          end else if (phase_q == low_len - CNT_W'(1)) begin
            state_d = HIGH;
            phase_d = '0;
          end
        end
        HIGH: begin
          if (expired) begin
            state_d = STARVE;
            phase_d = '0;
          end else if (phase_q == CNT_W'(FEED_HIGH - 1)) begin
            state_d = LOW;
            phase_d = '0;
          end
        end
        STARVE: begin
          phase_d = '0;
          if (wdog) begin
            state_d = RECOVER;
            bite_d  = bite_inc;
            if (bite_inc == BITE_W'(MAX_BITES)) begin
              rst_req_d = 1'b1;
            end
          end else if (alive) begin
            state_d = LOW;
            win_clr = 1'b1;
          end
        end
        RECOVER: begin
          if (phase_q == CNT_W'(FEED_LOW - 1)) begin
            state_d = LOW;
            phase_d = '0;
            win_clr = 1'b1;
          end
        end
        default: begin
          state_d = DISABLED;
          phase_d = '0;
        end
      endcase
    end
    feed_d     = (state_d == HIGH) || (state_d == STARVE);
    starving_d = (state_d == STARVE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= DISABLED;
      phase_q    <= '0;
      bite_q     <= '0;
      rst_req_q  <= 1'b0;
      spur_q     <= 1'b0;
      feed_q     <= 1'b0;
      starving_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      bite_q     <= bite_d;
      rst_req_q  <= rst_req_d;
      spur_q     <= spur_d;
      feed_q     <= feed_d;
      starving_q <= starving_d;
    end
  end

  assign feed          = feed_q;
  assign starving      = starving_q;
  assign bite_cnt      = bite_q;
  assign spurious_bite = spur_q;
  assign rst_req       = rst_req_q;

endmodule

// File: tb/tb_wd_feeder.sv
// Scoreboard bench for wd_feeder: a phase/countdown reference model queues the
// expected outputs per cycle and an independent monitor compares them.
module tb_wd_feeder;

  localparam int FH  = 8;
  localparam int FL  = 8;
  localparam int AW  = 256;
  localparam int MB  = 3;
  localparam int TMO = 100;

  localparam int M_OFF = 0, M_LOW = 1, M_HIGH = 2, M_STARVE = 3, M_RECOVER = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       en    = 1'b0;
  logic       alive = 1'b0;
  logic       wdog  = 1'b0;
  logic       feed, starving, spurious_bite, rst_req;
  logic [3:0] bite_cnt;

  wd_feeder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .alive         (alive),
    .wdog          (wdog),
    .feed          (feed),
    .starving      (starving),
    .bite_cnt      (bite_cnt),
    .spurious_bite (spurious_bite),
    .rst_req       (rst_req)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       feed;
    logic       starving;
    logic [3:0] bites;
    logic       spur;
    logic       rreq;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: mode, cycles left in the current phase, cycles since alive.
  int m_mode, m_left, m_idle, m_bites, feed_run;
  bit m_rreq, m_spur;

  task automatic model_reset();
    m_mode = M_OFF; m_left = 0; m_idle = 0; m_bites = 0;
    m_rreq = 0; m_spur = 0; feed_run = 0;
  endtask

  function automatic exp_t model_out();
    exp_t r;
    r.feed     = (m_mode == M_HIGH) || (m_mode == M_STARVE);
    r.starving = (m_mode == M_STARVE);
    r.bites    = 4'(m_bites);
    r.spur     = m_spur;
    r.rreq     = m_rreq;
    return r;
  endfunction

  task automatic model_step(input bit e, input bit a, input bit w);
    if (w && m_mode != M_STARVE) m_spur = 1;
    if (!e) begin
      m_mode = M_OFF; m_bites = 0; m_rreq = 0; m_idle = 0;
      return;
    end
    case (m_mode)
      M_OFF: begin
        m_mode = M_LOW; m_left = FL;
      end
      M_LOW, M_HIGH: begin
        if (a) begin
          m_bites = 0; m_idle = 0;
        end else if (m_idle == AW - 1) begin
          m_mode = M_STARVE;
          return;
        end else begin
          m_idle++;
        end
        m_left--;
        if (m_left == 0) begin
          if (m_mode == M_LOW) begin m_mode = M_HIGH; m_left = FH; end
          else begin m_mode = M_LOW; m_left = FL; end
        end
      end
      M_STARVE: begin
        if (w) begin
          m_bites = (m_bites < 15) ? m_bites + 1 : 15;
          if (m_bites == MB) m_rreq = 1;
          m_mode = M_RECOVER; m_left = FL;
        end else if (a) begin
          m_mode = M_LOW; m_left = FL; m_idle = 0;
        end
      end
      M_RECOVER: begin
        m_left--;
        if (m_left == 0) begin m_mode = M_LOW; m_left = FL; m_idle = 0; end
      end
      default: m_mode = M_OFF;
    endcase
  endtask

  task automatic cycle(input bit e, input bit a, input bit w);
    exp_t x;
    @(negedge clk);
    en = e; alive = a; wdog = w;
    model_step(e, a, w);
    x = model_out();
    exp_q.push_back(x);
    feed_run = x.feed ? feed_run + 1 : 0;
  endtask

  task automatic check(input string nm, input logic [7:0] got, input logic [7:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got %h expected %h", nm, got, want);
    end
  endtask

  task automatic timeout(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s wait bound expired", nm);
  endtask

  // Monitor: one scoreboard entry per clock edge that followed a stimulus cycle.
  initial begin
    exp_t got, want, last;
    last = '0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        got  = {feed, starving, bite_cnt, spurious_bite, rst_req};
        n_checks++;
        if (got !== want) begin
          n_fail++;
          $display("FAIL scoreboard t=%0t got feed=%b starving=%b bite_cnt=%0d spurious=%b rst_req=%b expected feed=%b starving=%b bite_cnt=%0d spurious=%b rst_req=%b",
                   $time, got.feed, got.starving, got.bites, got.spur, got.rreq,
                   want.feed, want.starving, want.bites, want.spur, want.rreq);
        end else if (want != last) begin
          $display("txn t=%0t feed=%b starving=%b bite_cnt=%0d spurious=%b rst_req=%b",
                   $time, got.feed, got.starving, got.bites, got.spur, got.rreq);
        end
        last = want;
      end
    end
  end

  initial begin
    int guard;
    bit r_e, r_a, r_w;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_values", {feed, starving, bite_cnt, spurious_bite, rst_req}, 8'h00);
    rst_n = 1'b1;

    // Healthy heartbeat: plain 8/8 pulse train, watchdog never bites.
    for (int i = 0; i < 400; i++) cycle(1, (i % 50) == 49, feed_run == TMO);

    // Silent heartbeat through three bites.
    guard = 0;
    while (m_bites < MB && guard < 2000) begin
      cycle(1, 0, feed_run == TMO);
      guard++;
    end
    if (guard >= 2000) timeout("three_bites");
    repeat (20) cycle(1, 0, feed_run == TMO);
    guard = 0;
    while (!(m_mode == M_LOW || m_mode == M_HIGH) && guard < 500) begin
      cycle(1, 0, feed_run == TMO);
      guard++;
    end
    if (guard >= 500) timeout("run_after_bites");
    cycle(1, 1, 0);
    repeat (20) cycle(1, 0, 0);
    repeat (2) cycle(0, 0, 0);

    // Heartbeat returns during STARVE before any bite.
    guard = 0;
    while (m_mode != M_STARVE && guard < 400) begin
      cycle(1, 0, 0);
      guard++;
    end
    if (guard >= 400) timeout("reach_starve");
    repeat (30) cycle(1, 0, 0);
    cycle(1, 1, 0);
    repeat (10) cycle(1, 0, 0);

    // Heartbeat on the exact window-expiry cycle.
    guard = 0;
    while (!((m_mode == M_LOW || m_mode == M_HIGH) && m_idle == AW - 1) && guard < 400) begin
      cycle(1, 0, 0);
      guard++;
    end
    if (guard >= 400) timeout("reach_expiry");
    cycle(1, 1, 0);
    repeat (30) cycle(1, 0, 0);

    // Stray bite during HIGH, then disable mid-HIGH.
    guard = 0;
    while (m_mode != M_HIGH && guard < 40) begin cycle(1, 1, 0); guard++; end
    if (guard >= 40) timeout("reach_high_spur");
    cycle(1, 0, 1);
    repeat (20) cycle(1, 0, 0);
    guard = 0;
    while (m_mode != M_HIGH && guard < 40) begin cycle(1, 0, 0); guard++; end
    if (guard >= 40) timeout("reach_high_dis");
    cycle(1, 0, 0);
    cycle(0, 0, 0);
    repeat (3) cycle(1, 1, 0);

    // Asynchronous reset in the middle of a HIGH pulse.
    guard = 0;
    while (m_mode != M_HIGH && guard < 40) begin cycle(1, 0, 0); guard++; end
    if (guard >= 40) timeout("reach_high_rst");
    cycle(1, 0, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset", {feed, starving, bite_cnt, spurious_bite, rst_req}, 8'h00);
    model_reset();
    @(negedge clk);
    en = 1'b0; alive = 1'b0; wdog = 1'b0;
    rst_n = 1'b1;

    // Random mix of enable drops, sparse heartbeats and stray bites.
    for (int i = 0; i < 3000; i++) begin
      r_e = ($urandom_range(0, 399) != 0);
      r_a = ($urandom_range(0, 179) == 0);
      r_w = (feed_run == TMO) || ($urandom_range(0, 299) == 0);
      cycle(r_e, r_a, r_w);
    end

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) timeout("scoreboard_drain");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
